// File: rtl/axil_mem_mailbox_if.sv
// Bus bundle for axil_mem_mailbox: host-side memory strobes (addr/wen/ren/
// data) plus the device-side TX and RX streaming handshakes.
// slave  = the mailbox itself, master = whoever drives the strobes/streams.
interface axil_mem_mailbox_if #(
  parameter int mem_addr_width_p = 8
);
  logic [mem_addr_width_p-1:0] addr_i;
  logic                        wen_i;
  logic                        ren_i;
  logic [31:0]                 data_i;
  logic [31:0]                 data_o;
  logic                        tx_v_o;
  logic [31:0]                 tx_data_o;
  logic                        tx_yumi_i;
  logic                        rx_v_i;
  logic [31:0]                 rx_data_i;
  logic                        rx_ready_o;

  modport slave (
    input  addr_i, wen_i, ren_i, data_i, tx_yumi_i, rx_v_i, rx_data_i,
    output data_o, tx_v_o, tx_data_o, rx_ready_o
  );

  modport master (
    output addr_i, wen_i, ren_i, data_i, tx_yumi_i, rx_v_i, rx_data_i,
    input  data_o, tx_v_o, tx_data_o, rx_ready_o
  );
endinterface

// File: rtl/axil_mem_mailbox.sv
// axil_mem_mailbox: polled host mailbox behind an AXI-Lite-to-memory front end.
// Register window: TX_DATA, TX_VACANCY, RX_DATA, RX_OCCUPANCY, SCRATCH, STATUS.
// Optional macro MAILBOX_IRQ_EN adds irq_o and the IRQ_EN register at 0x18.
module axil_mem_mailbox #(
  parameter  int mem_addr_width_p = 8,
  parameter  int els_p            = 16,
  localparam int count_width_lp   = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  axil_mem_mailbox_if.slave  bus
`ifdef MAILBOX_IRQ_EN
  ,
  output logic               irq_o
`endif
);
  localparam int aw_lp  = mem_addr_width_p;
  localparam int ptr_lp = $clog2(els_p);

  localparam logic [aw_lp-3:0] idx_tx_data   = (aw_lp-2)'(0);
  localparam logic [aw_lp-3:0] idx_tx_vac    = (aw_lp-2)'(1);
  localparam logic [aw_lp-3:0] idx_rx_data   = (aw_lp-2)'(2);
  localparam logic [aw_lp-3:0] idx_rx_occ    = (aw_lp-2)'(3);
  localparam logic [aw_lp-3:0] idx_scratch   = (aw_lp-2)'(4);
  localparam logic [aw_lp-3:0] idx_status    = (aw_lp-2)'(5);
  localparam logic [aw_lp-3:0] idx_irq_en    = (aw_lp-2)'(6);

  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

  // strobe history and request detection
  logic wen_reg, ren_reg;
  logic wr_req, rd_req;
  logic [aw_lp-3:0] word_addr;
  logic unused_addr_lsbs;

  assign word_addr        = bus.addr_i[aw_lp-1:2];
  assign unused_addr_lsbs = &{1'b0, bus.addr_i[1:0]};
  assign wr_req           = bus.wen_i & ~wen_reg;
  // a read colliding with a write is dropped; the write wins
  assign rd_req           = bus.ren_i & ~ren_reg & ~wr_req;

  // FIFO storage and bookkeeping
  logic [31:0]               tx_mem [els_p];
  logic [31:0]               rx_mem [els_p];
  logic [ptr_lp-1:0]         tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [ptr_lp-1:0]         rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [count_width_lp-1:0] tx_count_reg, rx_count_reg;
  logic [31:0]               scratch_reg, data_o_reg, rd_data_next;
  logic                      tx_overflow_reg, rx_underflow_reg;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr, tx_push, tx_pop, tx_ovf_set;
  logic rx_rd, rx_push, rx_pop, rx_unf_set;
  logic status_wr;
  logic [31:0] status_word;

  assign tx_full  = (tx_count_reg == full_count_lp);
  assign tx_empty = (tx_count_reg == '0);
  assign rx_full  = (rx_count_reg == full_count_lp);
  assign rx_empty = (rx_count_reg == '0);

  assign tx_pop     = bus.tx_yumi_i & ~tx_empty;
  assign tx_wr      = wr_req & (word_addr == idx_tx_data);
  // a same-cycle pop frees the slot, so a write to a full FIFO still lands
  assign tx_push    = tx_wr & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_wr & ~tx_push;

  assign rx_push    = bus.rx_v_i & ~rx_full;
  assign rx_rd      = rd_req & (word_addr == idx_rx_data);
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_unf_set = rx_rd & rx_empty;

  assign status_wr   = wr_req & (word_addr == idx_status);
  assign status_word = {28'd0, rx_underflow_reg, tx_overflow_reg, rx_empty, tx_full};

  assign bus.data_o     = data_o_reg;
  assign bus.tx_v_o     = ~tx_empty;
  assign bus.tx_data_o  = tx_mem[tx_rd_ptr_reg];
  assign bus.rx_ready_o = ~rx_full;

`ifdef MAILBOX_IRQ_EN
  logic irq_en_reg, irq_reg;
  assign irq_o = irq_reg;

  // interrupt enable register and registered RX-not-empty interrupt
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_req && word_addr == idx_irq_en) irq_en_reg <= bus.data_i[0];
      irq_reg <= irq_en_reg & ~rx_empty;
    end
  end
`endif

  // read-data mux for the register window
  always_comb begin
    rd_data_next = 32'd0;
    case (word_addr)
      idx_tx_vac:  rd_data_next = 32'(full_count_lp - tx_count_reg);
      idx_rx_data: rd_data_next = rx_empty ? 32'hdead_beef : rx_mem[rx_rd_ptr_reg];
      idx_rx_occ:  rd_data_next = 32'(rx_count_reg);
      idx_scratch: rd_data_next = scratch_reg;
      idx_status:  rd_data_next = status_word;
`ifdef MAILBOX_IRQ_EN
      idx_irq_en:  rd_data_next = {31'd0, irq_en_reg};
`endif
      default:     rd_data_next = 32'd0;
    endcase
  end

  // FIFO payload storage (no reset needed; validity tracked by counters)
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.data_i;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.rx_data_i;
  end

  // control state: strobe history, pointers, counters, registers, flags
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wen_reg          <= 1'b0;
      ren_reg          <= 1'b0;
      tx_wr_ptr_reg    <= '0;
      tx_rd_ptr_reg    <= '0;
      rx_wr_ptr_reg    <= '0;
      rx_rd_ptr_reg    <= '0;
      tx_count_reg     <= '0;
      rx_count_reg     <= '0;
      scratch_reg      <= 32'd0;
      data_o_reg       <= 32'd0;
      tx_overflow_reg  <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      wen_reg <= bus.wen_i;
      ren_reg <= bus.ren_i;

      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + ptr_lp'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + ptr_lp'(1);
      if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + count_width_lp'(1);
      else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - count_width_lp'(1);

      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + ptr_lp'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + ptr_lp'(1);
      if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + count_width_lp'(1);
      else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - count_width_lp'(1);

      if (wr_req && word_addr == idx_scratch) scratch_reg <= bus.data_i;
      if (rd_req) data_o_reg <= rd_data_next;

      if (tx_ovf_set)                       tx_overflow_reg <= 1'b1;
      else if (status_wr && bus.data_i[2])  tx_overflow_reg <= 1'b0;
      if (rx_unf_set)                       rx_underflow_reg <= 1'b1;
      else if (status_wr && bus.data_i[3])  rx_underflow_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_mem_mailbox.sv
// Directed self-checking bench for axil_mem_mailbox (default build).
module tb_axil_mem_mailbox;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rdata;

  axil_mem_mailbox_if #(.mem_addr_width_p(8)) bus ();
`ifdef MAILBOX_IRQ_EN
  logic irq;
`endif

  axil_mem_mailbox #(.mem_addr_width_p(8), .els_p(16)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
`ifdef MAILBOX_IRQ_EN
    , .irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    bus.addr_i = a; bus.data_i = d; bus.wen_i = 1'b1;
    repeat (hold) @(negedge clk);
    bus.wen_i = 1'b0;
    $display("write addr=%h data=%h hold=%0d", a, d, hold);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.ren_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.ren_i = 1'b0;
    d = bus.data_o;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic pop_tx();
    @(negedge clk);
    bus.tx_yumi_i = 1'b1;
    @(negedge clk);
    bus.tx_yumi_i = 1'b0;
  endtask

  initial begin
    bus.addr_i = '0; bus.wen_i = 0; bus.ren_i = 0; bus.data_i = '0;
    bus.tx_yumi_i = 0; bus.rx_v_i = 0; bus.rx_data_i = '0;

    // reset state
    #12;
    check("rst_data_o", bus.data_o, 32'h0);
    check("rst_tx_v", {31'd0, bus.tx_v_o}, 32'h0);
    check("rst_rx_ready", {31'd0, bus.rx_ready_o}, 32'h1);
    @(negedge clk); reset_n = 1'b1;

    do_read(8'h04, rdata); check("tx_vacancy_init", rdata, 32'd16);
    do_read(8'h0C, rdata); check("rx_occ_init", rdata, 32'd0);
    do_read(8'h14, rdata); check("status_init", rdata, 32'h2);

    // scratch write with strobe held 2 cycles
    do_write(8'h10, 32'h1234_5678, 2);
    do_read(8'h10, rdata); check("scratch_rw", rdata, 32'h1234_5678);

    // long-held TX write must push exactly once
    do_write(8'h00, 32'h5555_0001, 4);
    do_read(8'h04, rdata); check("one_push_per_strobe", rdata, 32'd15);
    check("tx_head_single", bus.tx_data_o, 32'h5555_0001);
    pop_tx();
    check("tx_v_after_pop", {31'd0, bus.tx_v_o}, 32'h0);

    // fill TX with 17 words, 17th overflows
    for (int i = 0; i < 17; i++) do_write(8'h00, 32'hA000_0000 + i, 2);
    check("tx_v_full", {31'd0, bus.tx_v_o}, 32'h1);
    check("tx_head_first", bus.tx_data_o, 32'hA000_0000);
    do_read(8'h14, rdata); check("status_overflow", rdata, 32'h7);
    do_read(8'h04, rdata); check("tx_vacancy_full", rdata, 32'd0);
    do_write(8'h14, 32'h4, 2);
    do_read(8'h14, rdata); check("status_w1c_ovf", rdata, 32'h3);

    // full FIFO: write coincident with pop
    @(negedge clk);
    bus.addr_i = 8'h00; bus.data_i = 32'hB000_0000; bus.wen_i = 1'b1; bus.tx_yumi_i = 1'b1;
    @(negedge clk);
    bus.tx_yumi_i = 1'b0;
    @(negedge clk);
    bus.wen_i = 1'b0;
    $display("write addr=00 data=b0000000 with tx_yumi");
    do_read(8'h14, rdata); check("status_no_ovf_coincident", rdata, 32'h3);
    do_read(8'h04, rdata); check("tx_vacancy_coincident", rdata, 32'd0);
    check("tx_head_after_coincident", bus.tx_data_o, 32'hA000_0001);
    pop_tx();
    check("tx_head_second_pop", bus.tx_data_o, 32'hA000_0002);
    for (int i = 0; i < 14; i++) pop_tx();
    check("tx_tail_word", bus.tx_data_o, 32'hB000_0000);
    pop_tx();
    check("tx_empty_end", {31'd0, bus.tx_v_o}, 32'h0);

    // RX: three words in, read back, underflow
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.rx_v_i = 1'b1; bus.rx_data_i = 32'hC000_0000 + i;
    end
    @(negedge clk); bus.rx_v_i = 1'b0;
    do_read(8'h0C, rdata); check("rx_occ_3", rdata, 32'd3);
    do_read(8'h08, rdata); check("rx_pop0", rdata, 32'hC000_0000);
    do_read(8'h08, rdata); check("rx_pop1", rdata, 32'hC000_0001);
    do_read(8'h08, rdata); check("rx_pop2", rdata, 32'hC000_0002);
    do_read(8'h08, rdata); check("rx_underflow_data", rdata, 32'hdead_beef);
    do_read(8'h14, rdata); check("status_underflow", rdata, 32'hA);
    do_write(8'h14, 32'h8, 2);
    do_read(8'h14, rdata); check("status_w1c_unf", rdata, 32'h2);

    // simultaneous write and read: write wins, data_o untouched
    @(negedge clk);
    bus.addr_i = 8'h10; bus.data_i = 32'hCAFE_F00D; bus.wen_i = 1'b1; bus.ren_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.wen_i = 1'b0; bus.ren_i = 1'b0;
    $display("write+read addr=10 data=cafef00d");
    check("wr_rd_collision_data_o", bus.data_o, 32'h2);
    do_read(8'h10, rdata); check("wr_rd_collision_write", rdata, 32'hCAFE_F00D);
    do_read(8'h18, rdata); check("unmapped_read", rdata, 32'h0);

    // RX full: rx_ready drops at 16 words, 17th refused
    @(negedge clk); bus.rx_v_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.rx_data_i = 32'hD000_0000 + i;
      @(negedge clk);
    end
    bus.rx_v_i = 1'b0;
    check("rx_ready_full", {31'd0, bus.rx_ready_o}, 32'h0);
    do_read(8'h0C, rdata); check("rx_occ_full", rdata, 32'd16);

    // asynchronous reset mid-strobe
    do_write(8'h00, 32'hE000_0000, 2);
    @(negedge clk);
    bus.addr_i = 8'h04; bus.ren_i = 1'b1;
    @(negedge clk);
    check("pre_reset_read", bus.data_o, 32'd15);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_data_o", bus.data_o, 32'h0);
    check("async_rst_tx_v", {31'd0, bus.tx_v_o}, 32'h0);
    check("async_rst_rx_ready", {31'd0, bus.rx_ready_o}, 32'h1);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("read_after_reset_release", bus.data_o, 32'd16);
    bus.ren_i = 1'b0;
    $display("read  addr=04 across reset data=%h", bus.data_o);
    do_read(8'h0C, rdata); check("rx_cleared_by_reset", rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axil_mem_mailbox.md
Name: axil_mem_mailbox

Overview:
- Memory-side target that consumes the addr/wen/ren/data strobes produced by the AXI-Lite-to-memory front end.
- Maps them onto a small register window, a host-to-device TX FIFO and a device-to-host RX FIFO.
- Sits between the host config path and device-side streaming logic (e.g. the manycore host endpoint); gives the host a polled mailbox with occupancy and error status.

Parameters:
- mem_addr_width_p, 8, width of addr_i; must be >= 5.
- els_p, 16, depth of each FIFO; power of two, >= 2.
- count_width_lp, $clog2(els_p+1), occupancy/vacancy counter width (derived).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- addr_i  in  mem_addr_width_p  byte address; addr_i[1:0] ignored.
- wen_i  in  1  write strobe; held >= 2 cycles per request.
- ren_i  in  1  read strobe; held >= 2 cycles per request.
- data_i  in  32  write data; valid while wen_i is high.
- data_o  out  32  read data, registered.
- tx_v_o  out  1  TX FIFO head valid.
- tx_data_o  out  32  TX FIFO head.
- tx_yumi_i  in  1  device consumes TX head; legal only when tx_v_o = 1.
- rx_v_i  in  1  device offers RX word.
- rx_data_i  in  32  RX word.
- rx_ready_o  out  1  RX FIFO not full.

Behaviour:
- Reset: data_o = 0, both FIFOs empty, tx_v_o = 0, rx_ready_o = 1, scratch = 0, sticky flags = 0, strobe history = 0.
- Request detection: a write request is wen_i & ~wen_q; a read request is ren_i & ~ren_q, where wen_q/ren_q are wen_i/ren_i registered each cycle.
  - Exactly one action per strobe, however long it is held.
  - Write and read requests in the same cycle: the write executes, the read is ignored and data_o is unchanged.
- Read latency: data_o is loaded on the request cycle's clock edge, so it is valid from the next cycle. It holds until the next read request; writes never change data_o.
- Address map (addr_i[mem_addr_width_p-1:2]):
  - 0x00 TX_DATA: W pushes data_i; R returns 0.
  - 0x04 TX_VACANCY: R returns els_p - tx_count, zero-extended.
  - 0x08 RX_DATA: R pops head. If empty, returns 32'hdead_beef, no pop, sets rx_underflow.
  - 0x0C RX_OCCUPANCY: R returns rx_count.
  - 0x10 SCRATCH: R/W, 32 bits.
  - 0x14 STATUS:
    - bit0 tx_full, bit1 rx_empty, bit2 tx_overflow (sticky), bit3 rx_underflow (sticky); other bits 0.
    - W1C on bits 2 and 3; other written bits ignored.
  - Any other address: R returns 0, W ignored.
  - Upper address bits above mem_addr_width_p are not seen by this block.
- TX FIFO:
  - Push when TX_DATA write and not full. Write while full: word dropped, tx_overflow set.
  - tx_yumi_i pops the head.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full, because the pop frees the slot first.
- RX FIFO:
  - Push when rx_v_i & rx_ready_o.
  - Host RX_DATA read pops the head.
  - Push and pop in the same cycle: count unchanged. When full, rx_ready_o stays 0 that cycle.
- Pointers: log2(els_p) bits, wrap naturally. Counters are 0..els_p and never wrap.
- Reset asserted mid-operation: all state clears asynchronously and queued words are lost. Strobe history clears, so a strobe still high after reset release counts as a new request.

Optional Feature:
- MAILBOX_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit, registered, reset 0) = irq_en & ~rx_empty, updated every cycle.
  - Adds register 0x18 IRQ_EN, R/W bit0, reset 0.
- Undefined: irq_o port absent; 0x18 reads 0, writes ignored.

Test Plan:
- Reset, then read 0x04, 0x0C, 0x14 -> data_o = 16, 0, 0x0000_0002.
- Write 0x10 = 32'h1234_5678 with wen_i held 2 cycles, then read 0x10 -> 32'h1234_5678; exactly one write action occurs.
- Push 17 words to 0x00 with tx_yumi_i = 0 -> tx_v_o = 1; tx_data_o = first word; STATUS = 0x0000_0007 (rx_empty still set). Write 0x14 = 0x4 -> STATUS = 0x0000_0003.
- Pulse rx_v_i with 3 words -> 0x0C = 3. Three RX_DATA reads return the words in order; a fourth read returns 32'hdead_beef and STATUS bit3 = 1.
- TX FIFO full, TX_DATA write coincident with tx_yumi_i -> no overflow, count stays 16, new word appears at the tail after 15 pops.
- Assert reset_n_i low mid-strobe (ren_i high) -> outputs return to reset values immediately, without waiting for a clock edge. After release with ren_i still high, one read executes.
